// File: rtl/fifo_drain_pkg.sv
// rtl/fifo_drain_pkg.sv - shared constants and types for the FIFO read-side drain
package fifo_drain_pkg;

    // Data width of the companion synchronous FIFO (din/dout)
    localparam int FIFO_WIDTH = 16;

    // Number of entries in the output skid buffer
    localparam int SKID_DEPTH = 2;

    // Width of the skid occupancy count (holds 0..SKID_DEPTH)
    localparam int OCC_W = 2;

    // What the skid buffer does at a clock edge
    typedef enum logic [1:0] {
        SKID_HOLD = 2'b00,  // nothing enters or leaves
        SKID_PUSH = 2'b01,  // a captured word enters, nothing leaves
        SKID_POP  = 2'b10,  // the head leaves, nothing enters
        SKID_PASS = 2'b11   // the head leaves and a captured word enters behind it
    } skid_op_e;

    // Decode the push/pop pair into a skid operation
    function automatic skid_op_e skid_op(input logic push, input logic pop);
        case ({pop, push})
            2'b01:   return SKID_PUSH;
            2'b10:   return SKID_POP;
            2'b11:   return SKID_PASS;
            default: return SKID_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/fifo_skid2.sv
// rtl/fifo_skid2.sv - two-entry valid/ready skid buffer, FIFO ordered
module fifo_skid2
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic [OCC_W-1:0] count;
    logic             deq;
    skid_op_e         op;

    assign deq       = (count != '0) && out_ready;
    assign op        = skid_op(in_valid, deq);
    assign out_valid = (count != '0);
    assign out_data  = head;
    assign occ       = count;

    // Head/tail storage and occupancy; the head only moves on a pop so out_data is stable under backpressure
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else begin
            case (op)
                SKID_PUSH: begin
                    if (count == '0) begin
                        head <= in_data;
                    end else begin
                        tail <= in_data;
                    end
                    count <= count + OCC_W'(1);
                end
                SKID_POP: begin
                    if (count == OCC_W'(SKID_DEPTH)) begin
                        head <= tail;
                    end
                    count <= count - OCC_W'(1);
                end
                SKID_PASS: begin
                    if (count == OCC_W'(1)) begin
                        head <= in_data;
                    end else begin
                        head <= tail;
                        tail <= in_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // A push into a full buffer without a pop would drop a word; the upstream credit check must prevent it
    assert property (@(posedge clk) disable iff (!rstn)
        !(in_valid && !deq && !clr && (count == OCC_W'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_drain.sv
// rtl/fifo_drain.sv - read-side controller popping a synchronous FIFO onto a valid/ready stream
module fifo_drain
    import fifo_drain_pkg::*;
#(
    parameter int WIDTH = FIFO_WIDTH,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             flush,
    output logic             readp,
    input  logic             emptyp,
    input  logic [WIDTH-1:0] fifo_dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CNT_W-1:0] words_out
);

    logic       infl;
    logic [1:0] occ;
    logic       deq;
    logic [2:0] pending;

    assign deq = out_valid && out_ready;

    // Entries the buffer will hold after this edge without a new pop: current words,
    // plus the word already in flight, minus the word leaving now. deq implies occ>=1,
    // so this never underflows. Using deq here keeps the stream at one word per clock.
    assign pending = {1'b0, occ} + {2'b00, infl} - {2'b00, deq};

    assign readp = rstn && en && !flush && !emptyp && (pending < 3'(SKID_DEPTH));

    // Remember that a pop was issued so its data is captured one cycle later
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            infl <= 1'b0;
        end else if (flush) begin
            infl <= 1'b0;
        end else begin
            infl <= readp;
        end
    end

    // Delivered-word counter; wraps naturally and ignores a deq that coincides with flush
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            words_out <= '0;
        end else if (deq && !flush) begin
            words_out <= words_out + CNT_W'(1);
        end
    end

    fifo_skid2 #(
        .WIDTH (WIDTH)
    ) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (flush),
        .in_valid  (infl),
        .in_data   (fifo_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occ       (occ)
    );

endmodule

// File: tb/tb_fifo_drain.sv
// tb/tb_fifo_drain.sv - directed self-checking bench for fifo_drain against a 4-entry FIFO model
module tb_fifo_drain;

    localparam int WIDTH = 16;
    localparam int CNT_W = 16;

    logic             clk       = 1'b0;
    logic             rstn      = 1'b0;
    logic             en        = 1'b0;
    logic             flush     = 1'b0;
    logic             out_ready = 1'b0;
    logic             readp;
    logic             emptyp;
    logic [WIDTH-1:0] fifo_dout = '0;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] words_out;

    // FIFO model write side and housekeeping
    logic             wr_en    = 1'b0;
    logic [15:0]      wr_data  = '0;
    logic             fifo_clr = 1'b1;
    logic [15:0]      mem [4];
    logic [1:0]       wp = '0;
    logic [1:0]       rp = '0;
    logic [2:0]       fcnt = '0;

    // Observation records, written only by the monitor
    logic [15:0]      got_q [$];
    int               got_cyc [$];
    int               rd_cyc [$];
    int               cyc = 0;
    int               rd_empty = 0;

    int               n_tests = 0;
    int               n_fail = 0;

    always #10 clk = ~clk;

    fifo_drain #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .en        (en),
        .flush     (flush),
        .readp     (readp),
        .emptyp    (emptyp),
        .fifo_dout (fifo_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .words_out (words_out)
    );

    assign emptyp = (fcnt == 3'd0);

    // Four-entry synchronous FIFO with registered dout
    always @(posedge clk) begin : fifo_model
        logic do_pop;
        logic do_push;
        if (fifo_clr) begin
            wp   <= '0;
            rp   <= '0;
            fcnt <= '0;
        end else begin
            do_pop  = readp && (fcnt != 3'd0);
            do_push = wr_en && ((fcnt != 3'd4) || do_pop);
            if (do_pop) begin
                fifo_dout <= mem[rp];
                rp        <= rp + 2'd1;
            end
            if (do_push) begin
                mem[wp] <= wr_data;
                wp      <= wp + 2'd1;
            end
            fcnt <= fcnt + {2'b00, do_push} - {2'b00, do_pop};
        end
    end

    // Record pops and delivered words with their cycle numbers
    always @(posedge clk) begin
        if (readp) rd_cyc.push_back(cyc);
        if (readp && emptyp) rd_empty = rd_empty + 1;
        if (rstn && out_valid && out_ready && !flush) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
        end
        cyc = cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write_word(input logic [15:0] w);
        wr_en   = 1'b1;
        wr_data = w;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic wait_words(input string tag, input int n, input int limit);
        int k;
        k = 0;
        while (got_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        check(tag, got_q.size(), n);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn     = 1'b0;
        fifo_clr = 1'b1;
        wr_en    = 1'b0;
        repeat (2) @(negedge clk);
        rstn     = 1'b1;
        fifo_clr = 1'b0;
    endtask

    initial begin
        int base_g;
        int base_r;
        int base_e;
        int k;
        logic [15:0] exp3 [4];
        exp3[0] = 16'h0001; exp3[1] = 16'h0002; exp3[2] = 16'h0003; exp3[3] = 16'h0004;

        repeat (3) @(negedge clk);
        rstn     = 1'b1;
        fifo_clr = 1'b0;

        // 1: reset in the middle of activity
        en = 1'b1;
        out_ready = 1'b1;
        base_g = got_q.size();
        write_word(16'h5555);
        write_word(16'h6666);
        wait_words("t1_pre_words", base_g + 2, 20);
        out_ready = 1'b0;
        write_word(16'h7771);
        write_word(16'h7772);
        write_word(16'h7773);
        @(negedge clk);
        #5 rstn = 1'b0;
        fifo_clr = 1'b1;
        #1;
        check("t1_rst_readp", readp, 0);
        check("t1_rst_valid", out_valid, 0);
        check("t1_rst_data", out_data, 0);
        check("t1_rst_words", words_out, 0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        fifo_clr = 1'b0;
        @(negedge clk);
        check("t1_rel_readp", readp, 0);
        check("t1_rel_valid", out_valid, 0);
        check("t1_rel_words", words_out, 0);

        // 2: three words streamed with the consumer always ready
        out_ready = 1'b1;
        base_g = got_q.size();
        base_r = rd_cyc.size();
        write_word(16'h1111);
        write_word(16'h2222);
        write_word(16'h3333);
        wait_words("t2_count", base_g + 3, 20);
        check("t2_data0", got_q[base_g],     16'h1111);
        check("t2_data1", got_q[base_g + 1], 16'h2222);
        check("t2_data2", got_q[base_g + 2], 16'h3333);
        check("t2_lat0", got_cyc[base_g],     rd_cyc[base_r] + 2);
        check("t2_lat1", got_cyc[base_g + 1], rd_cyc[base_r] + 3);
        check("t2_lat2", got_cyc[base_g + 2], rd_cyc[base_r] + 4);
        check("t2_pops", rd_cyc.size() - base_r, 3);
        check("t2_words", words_out, 3);

        // 3: backpressure with four words, then release
        out_ready = 1'b0;
        base_g = got_q.size();
        base_r = rd_cyc.size();
        write_word(16'h0001);
        write_word(16'h0002);
        write_word(16'h0003);
        write_word(16'h0004);
        repeat (5) @(negedge clk);
        check("t3_pops_held", rd_cyc.size() - base_r, 2);
        check("t3_valid_held", out_valid, 1);
        check("t3_data_held", out_data, 16'h0001);
        check("t3_fifo_held", fcnt, 2);
        check("t3_none_out", got_q.size(), base_g);
        out_ready = 1'b1;
        wait_words("t3_count", base_g + 4, 20);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_data%0d", i), got_q[base_g + i], exp3[i]);
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t3_gap%0d", i), got_cyc[base_g + i + 1] - got_cyc[base_g + i], 1);
        end
        check("t3_words", words_out, 7);

        // 4: single word, empty boundary
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        base_g = got_q.size();
        base_r = rd_cyc.size();
        base_e = rd_empty;
        write_word(16'h00AA);
        repeat (8) @(negedge clk);
        check("t4_pops", rd_cyc.size() - base_r, 1);
        check("t4_pop_empty", rd_empty - base_e, 0);
        check("t4_count", got_q.size() - base_g, 1);
        check("t4_data", got_q[base_g], 16'h00AA);
        check("t4_words", words_out, 1);

        // 5: en drops in the cycle after a pop
        en = 1'b0;
        write_word(16'hB001);
        write_word(16'hB002);
        write_word(16'hB003);
        base_g = got_q.size();
        base_r = rd_cyc.size();
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (6) @(negedge clk);
        check("t5_pops", rd_cyc.size() - base_r, 1);
        check("t5_count", got_q.size() - base_g, 1);
        check("t5_data", got_q[base_g], 16'hB001);
        check("t5_fifo", fcnt, 2);
        check("t5_words", words_out, 2);

        // 6: counter wrap and flush with two words buffered
        do_reset();
        en = 1'b1;
        out_ready = 1'b1;
        k = 0;
        while (words_out !== 16'hFFFF && k < 70000) begin
            wr_en   = (fcnt < 3'd4);
            wr_data = k[15:0];
            @(negedge clk);
            k++;
        end
        wr_en = 1'b0;
        out_ready = 1'b0;
        check("t6_words_ffff", words_out, 16'hFFFF);
        repeat (4) @(negedge clk);
        check("t6_buffered", out_valid, 1);
        flush = 1'b1;
        fifo_clr = 1'b1;
        out_ready = 1'b1;
        #1;
        check("t6_readp_flush", readp, 0);
        @(negedge clk);
        flush = 1'b0;
        fifo_clr = 1'b0;
        check("t6_valid_flush", out_valid, 0);
        check("t6_words_flush", words_out, 16'hFFFF);
        base_g = got_q.size();
        write_word(16'h00EE);
        wait_words("t6_count", base_g + 1, 10);
        check("t6_data", got_q[base_g], 16'h00EE);
        check("t6_wrap", words_out, 16'h0000);

        check("no_pop_when_empty", rd_empty, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
